key_entry_buffer: RTL and testbench

//   Downstream consumer of the debounced keypad scanner. Accepts one key code per
//   Key_ready/readn handshake and builds a hex number from digit keys.

---
 rtl/key_entry_buffer_if.sv | 18 +
 rtl/key_entry_buffer.sv | 86 ++++++++
 tb/tb_key_entry_buffer.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/key_entry_buffer_if.sv
// key_entry_buffer_if: keypad handshake, entry display and FIFO drain signals
interface key_entry_buffer_if #(parameter int WIDTH = 32, parameter int DEPTH = 4);
  logic Key_ready;
  logic [4:0] Key_out;
  logic readn;
  logic [WIDTH-1:0] entry;
  logic [$clog2(WIDTH/4):0] digit_cnt;
  logic [WIDTH-1:0] fifo_dout;
  logic fifo_valid;
  logic fifo_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic overflow;
  logic ovf_clr;
  modport master(output Key_ready, Key_out, fifo_ready, ovf_clr,
                 input readn, entry, digit_cnt, fifo_dout, fifo_valid, fifo_count, overflow);
  modport slave(input Key_ready, Key_out, fifo_ready, ovf_clr,
                output readn, entry, digit_cnt, fifo_dout, fifo_valid, fifo_count, overflow);
endinterface

// File: rtl/key_entry_buffer.sv
// key_entry_buffer: builds a hex number from keypad codes and queues it on enter
module key_entry_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter logic [4:0] KEY_BS = 5'd16,
  parameter logic [4:0] KEY_CLR = 5'd17,
  parameter logic [4:0] KEY_ENT = 5'd18
) (
  input logic clk,
  input logic rst,
  key_entry_buffer_if.slave bus
);
  localparam int CW = $clog2(WIDTH/4) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] MAXD = CW'(WIDTH/4);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, ACK = 2'd1, WAIT = 2'd2;
  logic [1:0] state;
  logic [4:0] key_r;
  logic readn;
  logic [WIDTH-1:0] entry;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic ovf;
  logic act, take, pop, push_ok, do_ent, push;
  assign take = state == IDLE && bus.Key_ready;
  assign act = state == ACK;
  assign pop = count != 0 && bus.fifo_ready;
  assign push_ok = count != FULL || pop;
  assign do_ent = act && key_r == KEY_ENT && cnt != 0;
  assign push = do_ent && push_ok;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      readn <= 1'b1;
      key_r <= '0;
    end else begin
      state <= take ? ACK : act ? WAIT : (state == WAIT && bus.Key_ready) ? WAIT : IDLE;
      readn <= !take;
      if (take) key_r <= bus.Key_out;
    end
  end
  // digits enter at the low nibble; a full entry drops its most significant digit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry <= '0;
      cnt <= '0;
    end else if (act) begin
      if (!key_r[4]) begin
        entry <= {entry[WIDTH-5:0], key_r[3:0]};
        cnt <= cnt == MAXD ? cnt : cnt + 1'b1;
      end else if (key_r == KEY_BS && cnt != 0) begin
        entry <= entry >> 4;
        cnt <= cnt - 1'b1;
      end else if (key_r == KEY_CLR || push) begin
        entry <= '0;
        cnt <= '0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
      ovf <= bus.ovf_clr ? 1'b0 : (do_ent && !push_ok) ? 1'b1 : ovf;
    end
  end
  assign bus.readn = readn;
  assign bus.entry = entry;
  assign bus.digit_cnt = cnt;
  assign bus.fifo_dout = mem[rd_ptr];
  assign bus.fifo_valid = count != 0;
  assign bus.fifo_count = count;
  assign bus.overflow = ovf;
endmodule

// File: tb/tb_key_entry_buffer.sv
// tb_key_entry_buffer: directed key sequences checked against a digit/queue model every cycle
module tb_key_entry_buffer;
  localparam logic [4:0] BS = 5'd16, CLR = 5'd17, ENT = 5'd18;
  logic clk = 1'b0;
  logic rst;
  int nchecks = 0;
  int nerrors = 0;
  int low_cycles = 0;
  logic [31:0] m_entry = '0;
  int m_cnt = 0;
  logic [31:0] m_q[$];
  bit m_ovf = 1'b0;
  bit exp_readn = 1'b1;
  bit key_due = 1'b0;
  key_entry_buffer_if #(.WIDTH(32), .DEPTH(4)) bus();
  key_entry_buffer #(.WIDTH(32), .DEPTH(4)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_entry = '0;
    m_cnt = 0;
    m_q.delete();
    m_ovf = 1'b0;
    exp_readn = 1'b1;
  endtask
  // One clock edge: the model applies whatever the DUT must apply at that edge
  task automatic tick();
    bit pop, set_ovf;
    logic [4:0] k;
    @(posedge clk);
    if (!rst) begin
      pop = m_q.size() > 0 && bus.fifo_ready;
      set_ovf = 1'b0;
      k = bus.Key_out;
      if (key_due) begin
        if (k < 16) begin
          m_entry = (m_entry << 4) | {28'd0, k[3:0]};
          m_cnt = m_cnt < 8 ? m_cnt + 1 : 8;
        end else if (k == BS && m_cnt > 0) begin
          m_entry = m_entry >> 4;
          m_cnt--;
        end else if (k == CLR) begin
          m_entry = '0;
          m_cnt = 0;
        end else if (k == ENT && m_cnt > 0) begin
          if (m_q.size() < 4 || pop) begin
            if (pop) void'(m_q.pop_front());
            pop = 1'b0;
            m_q.push_back(m_entry);
            m_entry = '0;
            m_cnt = 0;
          end else set_ovf = 1'b1;
        end
      end
      if (pop) void'(m_q.pop_front());
      m_ovf = bus.ovf_clr ? 1'b0 : set_ovf ? 1'b1 : m_ovf;
    end
    #1;
  endtask
  task automatic press(input logic [4:0] code, input int hold, input bit rdy);
    bus.Key_out = code;
    bus.Key_ready = 1'b1;
    tick();
    exp_readn = 1'b0;
    bus.fifo_ready = rdy;
    key_due = 1'b1;
    tick();
    key_due = 1'b0;
    exp_readn = 1'b1;
    bus.fifo_ready = 1'b0;
    repeat (hold - 2) tick();
    bus.Key_ready = 1'b0;
    tick();
  endtask
  always @(negedge clk) begin
    if (bus.readn === 1'b0) low_cycles++;
    chk("readn", {31'd0, bus.readn}, {31'd0, exp_readn});
    chk("entry", bus.entry, m_entry);
    chk("digit_cnt", {28'd0, bus.digit_cnt}, m_cnt);
    chk("fifo_count", {29'd0, bus.fifo_count}, m_q.size());
    chk("fifo_valid", {31'd0, bus.fifo_valid}, {31'd0, m_q.size() > 0});
    chk("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
    if (m_q.size() > 0) chk("fifo_dout", bus.fifo_dout, m_q[0]);
  end
  initial begin
    rst = 1'b1;
    bus.Key_ready = 1'b0;
    bus.Key_out = '0;
    bus.fifo_ready = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_readn", {31'd0, bus.readn}, 32'd1);
    chk("rst_entry", bus.entry, 32'd0);
    chk("rst_count", {29'd0, bus.fifo_count}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    low_cycles = 0;
    press(5'd1, 5, 1'b0);
    press(5'd2, 5, 1'b0);
    press(5'd3, 5, 1'b0);
    chk("t1_entry", bus.entry, 32'h123);
    chk("t1_cnt", {28'd0, bus.digit_cnt}, 32'd3);
    chk("t1_readn_lows", low_cycles, 32'd3);
    press(CLR, 2, 1'b0);
    for (int d = 1; d <= 9; d++) press(5'(d), 2, 1'b0);
    chk("t2_entry", bus.entry, 32'h23456789);
    chk("t2_cnt", {28'd0, bus.digit_cnt}, 32'd8);
    press(BS, 2, 1'b0);
    chk("t2_bs_entry", bus.entry, 32'h02345678);
    chk("t2_bs_cnt", {28'd0, bus.digit_cnt}, 32'd7);
    press(CLR, 3, 1'b0);
    chk("t2_clr", bus.entry, 32'd0);
    press(5'd10, 2, 1'b0);
    press(5'd11, 2, 1'b0);
    press(ENT, 2, 1'b0);
    chk("t3_dout", bus.fifo_dout, 32'hAB);
    chk("t3_count", {29'd0, bus.fifo_count}, 32'd1);
    chk("t3_entry", bus.entry, 32'd0);
    press(ENT, 2, 1'b0);
    chk("t3_empty_ent", {29'd0, bus.fifo_count}, 32'd1);
    press(5'd1, 2, 1'b0); press(ENT, 2, 1'b0);
    press(5'd2, 2, 1'b0); press(5'd2, 2, 1'b0); press(ENT, 2, 1'b0);
    for (int i = 0; i < 3; i++) press(5'd3, 2, 1'b0);
    press(ENT, 2, 1'b0);
    press(5'd4, 2, 1'b0);
    press(ENT, 2, 1'b0);
    chk("t4_ovf", {31'd0, bus.overflow}, 32'd1);
    chk("t4_kept", bus.entry, 32'h4);
    chk("t4_full", {29'd0, bus.fifo_count}, 32'd4);
    press(ENT, 2, 1'b1);
    chk("t4_pushpop_count", {29'd0, bus.fifo_count}, 32'd4);
    chk("t4_head", bus.fifo_dout, 32'h1);
    chk("t4_entry", bus.entry, 32'd0);
    press(5'd25, 3, 1'b0);
    press(BS, 2, 1'b0);
    chk("t5_entry", bus.entry, 32'd0);
    bus.ovf_clr = 1'b1;
    press(5'd7, 2, 1'b0);
    press(ENT, 2, 1'b0);
    bus.ovf_clr = 1'b0;
    chk("t5_clr_wins", {31'd0, bus.overflow}, 32'd0);
    chk("t5_kept", bus.entry, 32'h7);
    press(ENT, 2, 1'b0);
    chk("t5_ovf_again", {31'd0, bus.overflow}, 32'd1);
    bus.fifo_ready = 1'b1;
    tick();
    chk("drain_1", bus.fifo_dout, 32'h22);
    tick();
    chk("drain_2", bus.fifo_dout, 32'h333);
    tick();
    chk("drain_3", bus.fifo_dout, 32'h4);
    tick();
    chk("drain_empty", {31'd0, bus.fifo_valid}, 32'd0);
    tick();
    bus.fifo_ready = 1'b0;
    bus.Key_out = 5'd3;
    bus.Key_ready = 1'b1;
    tick();
    exp_readn = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    chk("t6_async_readn", {31'd0, bus.readn}, 32'd1);
    chk("t6_async_entry", bus.entry, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    exp_readn = 1'b0;
    key_due = 1'b1;
    tick();
    key_due = 1'b0;
    exp_readn = 1'b1;
    repeat (3) tick();
    bus.Key_ready = 1'b0;
    repeat (2) tick();
    chk("t6_once_entry", bus.entry, 32'h3);
    chk("t6_once_cnt", {28'd0, bus.digit_cnt}, 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end
endmodule
